// File: rtl/fp_class_stimulus_gen_if.sv
// Operand stream produced by fp_class_stimulus_gen: valid/ready handshake
// carrying an IEEE-754 operand, its FCLASS index and an end-of-run marker.
interface fp_class_stimulus_gen_if #(
  parameter int FLEN = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [FLEN-1:0] out_operand;
  logic [3:0]      out_class;
  logic            out_last;

  modport master (
    output out_valid,
    output out_operand,
    output out_class,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_operand,
    input  out_class,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fp_class_stimulus_gen.sv
// Inverse FCLASS: for every class requested in an FCLASS-encoded mask, streams
// SAMPLES_PER_CLASS LFSR-derived operands that are guaranteed to fall in that class.
module fp_class_stimulus_gen #(
  parameter int          FLEN              = 32,
  parameter int          SAMPLES_PER_CLASS = 4,
  parameter logic [31:0] LFSR_SEED         = 32'hACE12345
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [9:0]              class_mask,
  input  logic                    fmt,
  output logic                    busy,
  output logic                    done,
  fp_class_stimulus_gen_if.master out_if
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_SCAN    = 2'd1;
  localparam logic [1:0]  S_EMIT    = 2'd2;
  localparam logic [1:0]  S_FIN     = 2'd3;
  localparam logic [31:0] SEED      = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [7:0]  CNT_LAST  = 8'(SAMPLES_PER_CLASS - 1);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  logic [1:0]      state_q, state_d;
  logic [9:0]      rem_q, rem_d;
  logic            fmt_q, fmt_d;
  logic [3:0]      cur_q, cur_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic [3:0]      class_q, class_d;
  logic [FLEN-1:0] operand_q, operand_d;
  logic            hs_s;
  logic            emit_s;

  // Galois form of x^32+x^22+x^2+x+1, shifting right.
  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return {1'b0, r[31:1]} ^ ({32{r[0]}} & LFSR_TAPS);
  endfunction

  function automatic logic [3:0] lowest_set(input logic [9:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      idx = m[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [9:0] m);
    return (m != 10'd0) && ((m & (m - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [31:0] build_sp(input logic [3:0] cls, input logic [31:0] r);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = (cls < 4'd4);
    e = 8'h00;
    m = 23'h0;
    case (cls)
      4'd0, 4'd7: e = 8'hFF;
      4'd1, 4'd6: begin
        e = (r[30:23] == 8'h00) ? 8'h01 : ((r[30:23] == 8'hFF) ? 8'hFE : r[30:23]);
        m = r[22:0];
      end
      4'd2, 4'd5: m = (r[22:0] == 23'h0) ? 23'h1 : r[22:0];
      4'd3, 4'd4: m = 23'h0;
      4'd8: begin
        s = r[31];
        e = 8'hFF;
        m = {1'b0, (r[21:0] == 22'h0) ? 22'h1 : r[21:0]};
      end
      4'd9: begin
        s = r[31];
        e = 8'hFF;
        m = {1'b1, r[21:0]};
      end
      default: s = 1'b0;
    endcase
    return {s, e, m};
  endfunction

  // Double uses {r[19:0], r} as a 52-bit mantissa source.
  function automatic logic [63:0] build_dp(input logic [3:0] cls, input logic [31:0] r);
    logic        s;
    logic [10:0] e;
    logic [51:0] m;
    logic [51:0] src;
    src = {r[19:0], r};
    s   = (cls < 4'd4);
    e   = 11'h000;
    m   = 52'h0;
    case (cls)
      4'd0, 4'd7: e = 11'h7FF;
      4'd1, 4'd6: begin
        e = (r[30:20] == 11'h000) ? 11'h001 : ((r[30:20] == 11'h7FF) ? 11'h7FE : r[30:20]);
        m = src;
      end
      4'd2, 4'd5: m = (src == 52'h0) ? 52'h1 : src;
      4'd3, 4'd4: m = 52'h0;
      4'd8: begin
        s = r[31];
        e = 11'h7FF;
        m = {1'b0, (src[50:0] == 51'h0) ? 51'h1 : src[50:0]};
      end
      4'd9: begin
        s = r[31];
        e = 11'h7FF;
        m = {1'b1, src[50:0]};
      end
      default: s = 1'b0;
    endcase
    return {s, e, m};
  endfunction

  // Single results are NaN-boxed; the box falls away when FLEN is 32.
  function automatic logic [FLEN-1:0] build_operand(input logic [3:0] cls, input logic [31:0] r,
                                                    input logic dbl);
    logic [63:0] w;
    w = dbl ? build_dp(cls, r) : {32'hFFFF_FFFF, build_sp(cls, r)};
    return w[FLEN-1:0];
  endfunction

  assign hs_s = valid_q & out_if.out_ready;

  // Next-state logic for the IDLE/SCAN/EMIT/FIN sequencer.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fmt_d   = fmt_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = class_mask;
          fmt_d   = (FLEN == 64) ? fmt : 1'b0;
          lfsr_d  = SEED;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (rem_q == 10'd0) begin
          state_d = S_FIN;
        end else begin
          cur_d   = lowest_set(rem_q);
          cnt_d   = 8'd0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (hs_s) begin
          lfsr_d = lfsr_step(lfsr_q);
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) begin
            rem_d   = rem_q & ~(10'd1 << cur_q);
            state_d = (rem_d == 10'd0) ? S_FIN : S_SCAN;
          end else begin
            state_d = S_EMIT;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from next state so they come straight off flops.
  always_comb begin
    emit_s    = (state_d == S_EMIT);
    valid_d   = emit_s;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FIN);
    class_d   = emit_s ? cur_d : 4'd0;
    last_d    = emit_s && (cnt_d == CNT_LAST) && single_bit(rem_d);
    operand_d = emit_s ? build_operand(cur_d, lfsr_d, fmt_d) : {FLEN{1'b0}};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rem_q     <= 10'd0;
      fmt_q     <= 1'b0;
      cur_q     <= 4'd0;
      cnt_q     <= 8'd0;
      lfsr_q    <= SEED;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      class_q   <= 4'd0;
      operand_q <= {FLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      fmt_q     <= fmt_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      class_q   <= class_d;
      operand_q <= operand_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign out_if.out_valid   = valid_q;
  assign out_if.out_operand = operand_q;
  assign out_if.out_class   = class_q;
  assign out_if.out_last    = last_q;

endmodule

// File: tb/tb_fp_class_stimulus_gen.sv
// Scoreboard bench: a 32-bit and a 64-bit generator, expected operands derived
// from the class rules and an independent LFSR model, plus an FCLASS cross-check.
module tb_fp_class_stimulus_gen;

  localparam int          SPC  = 4;
  localparam logic [31:0] SEED = 32'hACE12345;

  typedef struct packed {
    logic [63:0] op;
    logic [3:0]  cls;
    logic        last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start32, start64;
  logic [9:0] class_mask;
  logic       fmt;
  logic       busy32, done32, busy64, done64;

  fp_class_stimulus_gen_if #(.FLEN(32)) if32 ();
  fp_class_stimulus_gen_if #(.FLEN(64)) if64 ();

  fp_class_stimulus_gen u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .class_mask(class_mask), .fmt(fmt),
    .busy(busy32), .done(done32), .out_if(if32)
  );

  fp_class_stimulus_gen #(.FLEN(64)) u_dut64 (
    .clk(clk), .reset(reset), .start(start64), .class_mask(class_mask), .fmt(fmt),
    .busy(busy64), .done(done64), .out_if(if64)
  );

  int   n_cmp = 0, n_bad = 0, cyc = 0;
  bit   stall_en = 1'b0, fmt_cur = 1'b0;
  exp_t q32[$], q64[$];
  int   hs32 = 0, hs64 = 0, first32 = -1, first64 = -1, lasths32 = -1, lasths64 = -1;
  bit   pst32 = 1'b0, pst64 = 1'b0;
  exp_t prv32, prv64;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    if32.out_ready = 1'b1;
    if64.out_ready = 1'b1;
    forever begin
      logic r;
      @(posedge clk);
      #1;
      r = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if32.out_ready = r;
      if64.out_ready = r;
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] r);
    logic [31:0] n;
    n = r >> 1;
    if (r[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic logic [63:0] m_op(input int c, input logic [31:0] r, input bit dbl);
    logic        s;
    logic [7:0]  e8;
    logic [22:0] m23;
    logic [10:0] e11;
    logic [51:0] m52, src;
    s = (c < 4);
    if (!dbl) begin
      e8 = 8'h00; m23 = 23'h0;
      if (c == 0 || c == 7) e8 = 8'hFF;
      else if (c == 1 || c == 6) begin
        e8 = r[30:23];
        if (e8 == 8'h00) e8 = 8'h01;
        if (e8 == 8'hFF) e8 = 8'hFE;
        m23 = r[22:0];
      end else if (c == 2 || c == 5) begin
        m23 = r[22:0];
        if (m23 == 23'h0) m23 = 23'h1;
      end else if (c == 8) begin
        s = r[31]; e8 = 8'hFF; m23 = {1'b0, r[21:0]};
        if (m23 == 23'h0) m23 = 23'h1;
      end else if (c == 9) begin
        s = r[31]; e8 = 8'hFF; m23 = {1'b1, r[21:0]};
      end
      return {32'hFFFF_FFFF, s, e8, m23};
    end
    src = {r[19:0], r}; e11 = 11'h000; m52 = 52'h0;
    if (c == 0 || c == 7) e11 = 11'h7FF;
    else if (c == 1 || c == 6) begin
      e11 = r[30:20];
      if (e11 == 11'h000) e11 = 11'h001;
      if (e11 == 11'h7FF) e11 = 11'h7FE;
      m52 = src;
    end else if (c == 2 || c == 5) begin
      m52 = src;
      if (m52 == 52'h0) m52 = 52'h1;
    end else if (c == 8) begin
      s = r[31]; e11 = 11'h7FF; m52 = {1'b0, src[50:0]};
      if (m52 == 52'h0) m52 = 52'h1;
    end else if (c == 9) begin
      s = r[31]; e11 = 11'h7FF; m52 = {1'b1, src[50:0]};
    end
    return {s, e11, m52};
  endfunction

  // Reference FCLASS, used to confirm every operand lands in its advertised class.
  function automatic logic [9:0] fclass(input logic [63:0] x, input bit dbl);
    logic s, all1, zexp, zman, q;
    if (dbl) begin
      s = x[63]; all1 = &x[62:52]; zexp = ~|x[62:52]; zman = ~|x[51:0]; q = x[51];
    end else begin
      s = x[31]; all1 = &x[30:23]; zexp = ~|x[30:23]; zman = ~|x[22:0]; q = x[22];
    end
    if (all1) return zman ? (s ? 10'h001 : 10'h080) : (q ? 10'h200 : 10'h100);
    if (zexp) return zman ? (s ? 10'h008 : 10'h010) : (s ? 10'h004 : 10'h020);
    return s ? 10'h002 : 10'h040;
  endfunction

  task automatic push_run(input bit is64, input logic [9:0] mask, input bit f);
    logic [31:0] r;
    logic [63:0] op;
    exp_t        e;
    int          total, n;
    r = SEED; n = 0; total = $countones(mask) * SPC;
    for (int c = 0; c < 10; c++) begin
      if (mask[c]) begin
        for (int s = 0; s < SPC; s++) begin
          n++;
          op     = m_op(c, r, is64 && f);
          e.op   = is64 ? op : {32'h0, op[31:0]};
          e.cls  = 4'(c);
          e.last = (n == total);
          if (is64) q64.push_back(e); else q32.push_back(e);
          r = m_step(r);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t obs, e;
    obs = {{32'h0, if32.out_operand}, if32.out_class, if32.out_last};
    if (reset) pst32 = 1'b0;
    else begin
      if (if32.out_valid && first32 < 0) first32 = cyc;
      if (pst32) begin
        chk("stall_valid32", 72'(if32.out_valid), 72'd1);
        chk("stall_hold32", 72'(obs), 72'(prv32));
      end
      if (if32.out_valid && if32.out_ready) begin
        hs32++; lasths32 = cyc; n_cmp++;
        assert (q32.size() > 0) else begin
          n_bad++;
          $error("FAIL sb_extra32: observed operand %0h expected none", if32.out_operand);
        end
        if (q32.size() > 0) begin
          e = q32.pop_front();
          chk("sb32", 72'(obs), 72'(e));
        end
        chk("fclass32", 72'(fclass({32'hFFFF_FFFF, if32.out_operand}, 1'b0)),
            72'(10'd1 << if32.out_class));
      end
      pst32 = if32.out_valid && !if32.out_ready;
      prv32 = obs;
    end
  end

  always @(negedge clk) begin
    exp_t obs, e;
    obs = {if64.out_operand, if64.out_class, if64.out_last};
    if (reset) pst64 = 1'b0;
    else begin
      if (if64.out_valid && first64 < 0) first64 = cyc;
      if (pst64) begin
        chk("stall_valid64", 72'(if64.out_valid), 72'd1);
        chk("stall_hold64", 72'(obs), 72'(prv64));
      end
      if (if64.out_valid && if64.out_ready) begin
        hs64++; lasths64 = cyc; n_cmp++;
        assert (q64.size() > 0) else begin
          n_bad++;
          $error("FAIL sb_extra64: observed operand %0h expected none", if64.out_operand);
        end
        if (q64.size() > 0) begin
          e = q64.pop_front();
          chk("sb64", 72'(obs), 72'(e));
        end
        chk("fclass64", 72'(fclass(if64.out_operand, fmt_cur)), 72'(10'd1 << if64.out_class));
      end
      pst64 = if64.out_valid && !if64.out_ready;
      prv64 = obs;
    end
  end

  task automatic chk_zero(input bit is64);
    if (is64) begin
      chk("zero_valid64", 72'(if64.out_valid), 72'd0);
      chk("zero_operand64", 72'(if64.out_operand), 72'd0);
      chk("zero_class64", 72'(if64.out_class), 72'd0);
      chk("zero_last64", 72'(if64.out_last), 72'd0);
      chk("zero_done64", 72'(done64), 72'd0);
      chk("zero_busy64", 72'(busy64), 72'd0);
    end else begin
      chk("zero_valid32", 72'(if32.out_valid), 72'd0);
      chk("zero_operand32", 72'(if32.out_operand), 72'd0);
      chk("zero_class32", 72'(if32.out_class), 72'd0);
      chk("zero_last32", 72'(if32.out_last), 72'd0);
      chk("zero_done32", 72'(done32), 72'd0);
      chk("zero_busy32", 72'(busy32), 72'd0);
    end
  endtask

  task automatic run(input bit is64, input logic [9:0] mask, input bit f, input bit stall);
    int t0, k, done_cyc, busy_cyc, hs0;
    push_run(is64, mask, f);
    fmt_cur  = is64 && f;
    stall_en = stall;
    k        = $countones(mask);
    @(posedge clk);
    #1;
    class_mask = mask; fmt = f; start32 = !is64; start64 = is64; t0 = cyc;
    if (is64) begin first64 = -1; hs0 = hs64; end else begin first32 = -1; hs0 = hs32; end
    @(posedge clk);
    #1;
    start32 = 1'b0; start64 = 1'b0; class_mask = ~mask; fmt = ~f;
    done_cyc = -1; busy_cyc = 0;
    for (int i = 0; i < 4000 && done_cyc < 0; i++) begin
      @(negedge clk);
      if (is64 ? busy64 : busy32) busy_cyc++;
      if (is64 ? done64 : done32) done_cyc = cyc;
    end
    chk("done_seen", 72'(done_cyc >= 0), 72'd1);
    chk("handshakes", 72'((is64 ? hs64 : hs32) - hs0), 72'(k * SPC));
    chk("sb_drained", 72'(is64 ? q64.size() : q32.size()), 72'd0);
    chk("busy_cycles", 72'(busy_cyc), 72'(done_cyc - t0));
    if (!stall) chk("done_latency", 72'(done_cyc - t0), 72'((k == 0) ? 2 : 1 + k * (SPC + 1)));
    if (k > 0) begin
      chk("done_after_last", 72'(done_cyc - (is64 ? lasths64 : lasths32)), 72'd1);
      if (!stall) chk("first_valid", 72'((is64 ? first64 : first32) - t0), 72'd2);
    end else begin
      chk("no_valid", 72'(is64 ? first64 : first32), 72'(-1));
    end
    @(negedge clk);
    chk("done_pulse", 72'(is64 ? done64 : done32), 72'd0);
    chk("idle_busy", 72'(is64 ? busy64 : busy32), 72'd0);
    stall_en = 1'b0;
  endtask

  initial begin
    int hs0;
    reset = 1'b1; start32 = 1'b0; start64 = 1'b0; class_mask = 10'd0; fmt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero(1'b0);
    chk_zero(1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(1'b0, 10'h010, 1'b0, 1'b0);
    run(1'b0, 10'h081, 1'b0, 1'b0);
    run(1'b0, 10'h000, 1'b0, 1'b0);
    run(1'b1, 10'h000, 1'b1, 1'b0);
    run(1'b1, 10'h3FF, 1'b0, 1'b0);
    run(1'b1, 10'h3FF, 1'b1, 1'b0);
    run(1'b1, 10'h3FF, 1'b0, 1'b1);
    run(1'b1, 10'h3FF, 1'b1, 1'b1);
    run(1'b0, 10'h3FF, 1'b0, 1'b1);

    // Abort a double run mid-class-6, then confirm a fresh run restarts bit-exactly.
    push_run(1'b1, 10'h0C0, 1'b1);
    fmt_cur = 1'b1;
    @(posedge clk);
    #1;
    class_mask = 10'h0C0; fmt = 1'b1; start64 = 1'b1; hs0 = hs64;
    @(posedge clk);
    #1;
    start64 = 1'b0;
    for (int i = 0; i < 50 && hs64 < hs0 + 2; i++) @(negedge clk);
    chk("pre_reset_valid", 72'(if64.out_valid), 72'd1);
    chk("pre_reset_class", 72'(if64.out_class), 72'd6);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q64.delete();
    @(negedge clk);
    chk_zero(1'b1);
    run(1'b1, 10'h0C0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_class_stimulus_gen.md
Name: fp_class_stimulus_gen

Overview:
Sequential operand generator that inverts FCLASS. It takes a 10-bit class mask in the FCLASS bit encoding. For each set class, it emits SAMPLES_PER_CLASS IEEE-754 operands guaranteed to belong to that class, over a valid/ready stream. It feeds FPU self-test and bring-up benches, and its output is checked by running it through the FCLASS unit.

Parameters:
FLEN, 32, FP register width: 32 (single only) or 64 (single + double).
SAMPLES_PER_CLASS, 4, operands emitted per requested class (1..255).
LFSR_SEED, 32'hACE12345, reset/start seed of the 32-bit LFSR; a value of 0 is replaced by 1.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
class_mask  input  10  FCLASS-encoded class request, latched on accepted start
fmt  input  1  0 single, 1 double; latched on start; forced 0 when FLEN=32
busy  output  1  high in every state except IDLE
out_valid  output  1  operand available
out_ready  input  1  consumer accepts operand
out_operand  output  FLEN  generated operand
out_class  output  4  class index 0..9 of out_operand
out_last  output  1  high with the final operand of the run
done  output  1  one-cycle pulse at the end of the run

Behaviour:
- Clocking and reset: single clock; synchronous active-high reset.
- Reset values:
  - FSM returns to IDLE.
  - busy, out_valid, out_last, done = 0; out_operand = 0; out_class = 0.
  - Latched mask = 0; sample counter = 0; LFSR = LFSR_SEED.
- Reset wins over every other input, including mid-run. Any in-flight operand is dropped.
- FSM states:
  - IDLE: start=1 latches class_mask into rem_mask and latches fmt, reloads LFSR = LFSR_SEED, then goes to SCAN.
  - SCAN (1 cycle): if rem_mask = 0, go to FIN. Otherwise cur_class = index of the lowest set bit of rem_mask, counter = 0, go to EMIT.
  - EMIT:
    - out_valid = 1; the operand is built from cur_class and the current LFSR value.
    - Handshake = out_valid & out_ready. On each handshake the LFSR steps once and counter increments.
    - On the handshake with counter = SAMPLES_PER_CLASS-1: clear bit cur_class in rem_mask; go to FIN if the cleared mask is 0, else to SCAN.
  - FIN: done = 1 for one cycle, then go to IDLE.
- Latency: start at cycle t gives out_valid at t+2. A class change costs one bubble cycle (SCAN). With mask = 0, done pulses at t+2.
- Stream rules:
  - While out_valid=1 and out_ready=0, out_operand, out_class and out_last stay stable.
  - out_valid never drops without a handshake, except on reset.
  - out_last = 1 when counter = SAMPLES_PER_CLASS-1 and rem_mask has exactly one bit set.
- start is ignored while busy. class_mask and fmt changes mid-run have no effect.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. It steps only on handshake, so sequences are fully deterministic. r denotes the current LFSR value.
- Single-precision operand construction (s = sign, e = 8-bit exponent, m = 23-bit mantissa):
  - Classes 0-3 have s=1; classes 4-7 have s=0.
  - inf (0, 7): e=FF, m=0.
  - normal (1, 6): e=r[30:23], with 00 mapped to 01 and FF mapped to FE; m=r[22:0].
  - subnormal (2, 5): e=0, m=r[22:0], with 0 mapped to 1.
  - zero (3, 4): e=0, m=0.
  - sNaN (8): s=r[31], e=FF, m[22]=0, m[21:0]=r[21:0], with 0 mapped to 1.
  - qNaN (9): s=r[31], e=FF, m[22]=1, m[21:0]=r[21:0].
- Double (FLEN=64, fmt=1):
  - Same rules, but e is 11 bits and m is 52 bits.
  - Normal exponent = r[30:20], with 000 mapped to 001 and 7FF mapped to 7FE.
  - Mantissa random source = {r[19:0], r}; NaN quiet bit is m[51].
- FLEN=64, fmt=0: out_operand[63:32] = 32'hFFFFFFFF (NaN-boxed); [31:0] follows the single rules.
- Classes are emitted in ascending index order. The total number of operands per run = popcount(mask) * SAMPLES_PER_CLASS.

Test Plan:
- mask=10'h010, out_ready=1, default parameters -> out_valid rises at t+2; four operands 32'h00000000 with out_class=4; out_last on the 4th; done pulses the next cycle.
- mask=10'h081 -> four 32'hFF800000 (class 0), then one bubble cycle, then four 32'h7F800000 (class 7); out_last only on the 8th operand.
- mask=10'h3FF, FLEN=64, fmt in {0,1}, output fed to the FCLASS unit -> all 40 operands classify to 1<<out_class; for fmt=0, bits [63:32] are all ones.
- Same run with out_ready randomly low 50% of cycles -> operand, class and last stay stable while stalled; the operand sequence is identical to the out_ready=1 run; exactly 40 handshakes.
- mask=0 -> busy high for 2 cycles, done at t+2, out_valid never asserted.
- Reset asserted during EMIT of class 6 -> the next cycle all outputs are 0 and the FSM is in IDLE; a new start with the same mask reproduces the first operand of the original run bit-exactly.
